// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the memory-stage load/store unit.
//   size_e   : access size after decoding Byte_Half_OpM
//   state_e  : LSU bus-access FSM states
//   LSU_LOAD_SRC : ResultSrcM encoding that marks a load
//   decode_size  : maps the 2-bit Byte_Half_OpM field to size_e
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    localparam logic [2:0] LSU_LOAD_SRC = 3'b001;

    // Encoding 2'b11 is not a distinct size; it behaves as a word access.
    function automatic size_e decode_size(input logic [1:0] i_op);
        size_e w_sz;
        case (i_op)
            2'b01:   w_sz = SZ_HALF;
            2'b10:   w_sz = SZ_BYTE;
            default: w_sz = SZ_WORD;
        endcase
        return w_sz;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu_if
// Data-bus request/acknowledge interface between the LSU and data memory.
//   dbus_req   : request, held high for the whole access
//   dbus_we    : 1 = write
//   dbus_addr  : word-aligned byte address
//   dbus_be    : byte enables
//   dbus_wdata : lane-replicated write data
//   dbus_ack   : single-cycle completion pulse from memory
//   dbus_rdata : read word, valid together with dbus_ack
// Modports: master (LSU side), slave (memory side).
// -----------------------------------------------------------------------------
interface mem_stage_lsu_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output dbus_ack, dbus_rdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Combinational byte-lane steering for a 32-bit little-endian data bus.
// Inputs:
//   i_size       : access size
//   i_addr       : byte offset within the word (addr[1:0])
//   i_sign       : 1 = sign-extend loaded byte/half, 0 = zero-extend
//   i_store_data : store data, byte/half in the low bits
//   i_read_word  : word returned by memory
// Outputs:
//   o_be         : store byte enables for the addressed lanes
//   o_wdata      : store data replicated across all lanes
//   o_load_data  : addressed lane extracted from i_read_word and extended
// -----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
(
    input  size_e       i_size,
    input  logic [1:0]  i_addr,
    input  logic        i_sign,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_read_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    function automatic logic [31:0] ext_byte(input logic [7:0] i_b, input logic i_s);
        logic signed [7:0] w_sb;
        w_sb = signed'(i_b);
        return i_s ? 32'(w_sb) : {24'b0, i_b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] i_h, input logic i_s);
        logic signed [15:0] w_sh;
        w_sh = signed'(i_h);
        return i_s ? 32'(w_sh) : {16'b0, i_h};
    endfunction

    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;

    assign w_rd_byte = i_read_word[{i_addr, 3'b000} +: 8];
    // Half accesses select the lane by addr[1] only; addr[0] never shifts the lane.
    assign w_rd_half = i_addr[1] ? i_read_word[31:16] : i_read_word[15:0];

    always_comb begin
        o_be        = 4'b1111;
        o_wdata     = i_store_data;
        o_load_data = i_read_word;
        case (i_size)
            SZ_BYTE: begin
                o_be        = 4'b0001 << i_addr;
                o_wdata     = {4{i_store_data[7:0]}};
                o_load_data = ext_byte(w_rd_byte, i_sign);
            end
            SZ_HALF: begin
                o_be        = i_addr[1] ? 4'b1100 : 4'b0011;
                o_wdata     = {2{i_store_data[15:0]}};
                o_load_data = ext_half(w_rd_half, i_sign);
            end
            default: begin
                o_be        = 4'b1111;
                o_wdata     = i_store_data;
                o_load_data = i_read_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// Memory-stage load/store unit. Takes the E2M register outputs, performs one
// data-bus access per load/store, stalls the pipeline until the access ends
// and presents formatted load data towards M2W.
//
// Parameters:
//   ACK_TIMEOUT : max REQ cycles without dbus_ack before the access aborts (>=1)
//   LOAD_SRC    : ResultSrcM value that marks a load
// Optional build macro:
//   LSU_MISALIGN_TRAP_EN : misaligned half/word accesses skip the bus and
//                          pulse MisalignM instead; undefined = MisalignM tied 0
//                          and misaligned low address bits are ignored.
// Ports:
//   CLK, RST        : clock (rising edge), asynchronous active-high reset
//   MemWriteM       : store request
//   ResultSrcM      : result select, == LOAD_SRC marks a load
//   signM           : 1 = sign-extend load, 0 = zero-extend
//   Byte_Half_OpM   : 00 word, 01 half, 10 byte, 11 word
//   ALUResultM      : byte address
//   WriteDataM      : store data
//   dbus            : data bus, master side
//   ReadDataM       : formatted load data (registered)
//   StallM          : holds PC/F2D/D2E/E2M, bubbles M2W
//   BusErrM         : one-cycle pulse after an ack timeout
//   MisalignM       : one-cycle pulse after a trapped misaligned access
// -----------------------------------------------------------------------------
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int         ACK_TIMEOUT = 255,
    parameter logic [2:0] LOAD_SRC    = LSU_LOAD_SRC
)(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  MemWriteM,
    input  logic [2:0]            ResultSrcM,
    input  logic                  signM,
    input  logic [1:0]            Byte_Half_OpM,
    input  logic [31:0]           ALUResultM,
    input  logic [31:0]           WriteDataM,
    mem_stage_lsu_if.master       dbus,
    output logic [31:0]           ReadDataM,
    output logic                  StallM,
    output logic                  BusErrM,
    output logic                  MisalignM
);

    localparam int                CNT_W   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LIM = CNT_W'(ACK_TIMEOUT - 1);

    state_e           r_state;
    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    size_e            r_size;
    logic             r_sign;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rdata;
    logic             r_buserr;
    logic             r_mis;

    logic             w_access;
    logic             w_idle;
    size_e            w_size;
    logic             w_misalign;
    size_e            w_lane_size;
    logic [1:0]       w_lane_addr;
    logic             w_lane_sign;
    logic [3:0]       w_lane_be;
    logic [31:0]      w_lane_wdata;
    logic [31:0]      w_lane_load;
    logic [3:0]       w_be_req;

    assign w_access = MemWriteM | (ResultSrcM == LOAD_SRC);
    assign w_idle   = (r_state == S_IDLE);
    assign w_size   = decode_size(Byte_Half_OpM);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((w_size == SZ_HALF) && ALUResultM[0]) ||
                        ((w_size == SZ_WORD) && (ALUResultM[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // One aligner serves both directions: in IDLE it formats the incoming
    // store from the live E2M inputs; in REQ it extracts the load lane using
    // the latched request so E2M changes cannot disturb the result.
    assign w_lane_size = w_idle ? w_size          : r_size;
    assign w_lane_addr = w_idle ? ALUResultM[1:0] : r_addr[1:0];
    assign w_lane_sign = w_idle ? signM           : r_sign;

    lsu_lane_align u_lane_align (
        .i_size       (w_lane_size),
        .i_addr       (w_lane_addr),
        .i_sign       (w_lane_sign),
        .i_store_data (WriteDataM),
        .i_read_word  (dbus.dbus_rdata),
        .o_be         (w_lane_be),
        .o_wdata      (w_lane_wdata),
        .o_load_data  (w_lane_load)
    );

    // Loads always fetch the full word; lane selection happens on return.
    assign w_be_req = MemWriteM ? w_lane_be : 4'b1111;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 32'b0;
            r_be     <= 4'b0;
            r_wdata  <= 32'b0;
            r_size   <= SZ_WORD;
            r_sign   <= 1'b0;
            r_cnt    <= '0;
            r_rdata  <= 32'b0;
            r_buserr <= 1'b0;
            r_mis    <= 1'b0;
        end else begin
            r_buserr <= 1'b0;
            r_mis    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        if (w_misalign) begin
                            r_state <= S_DONE;
                            r_mis   <= 1'b1;
                            r_rdata <= 32'b0;
                        end else begin
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                            r_we    <= MemWriteM;
                            r_addr  <= ALUResultM;
                            r_be    <= w_be_req;
                            r_wdata <= w_lane_wdata;
                            r_size  <= w_size;
                            r_sign  <= signM;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_REQ: begin
                    // Ack is tested first so an ack coinciding with the
                    // timeout limit completes normally.
                    if (dbus.dbus_ack) begin
                        r_state <= S_DONE;
                        r_req   <= 1'b0;
                        r_rdata <= r_we ? 32'b0 : w_lane_load;
                    end else if (r_cnt == CNT_LIM) begin
                        r_state  <= S_DONE;
                        r_req    <= 1'b0;
                        r_rdata  <= 32'b0;
                        r_buserr <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // Always return to IDLE so the same E2M access, still
                    // present this cycle, is not issued twice.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign StallM = (w_idle && w_access) || (r_state == S_REQ);

    assign dbus.dbus_req   = r_req;
    assign dbus.dbus_we    = r_we;
    assign dbus.dbus_addr  = {r_addr[31:2], 2'b00};
    assign dbus.dbus_be    = r_be;
    assign dbus.dbus_wdata = r_wdata;

    assign ReadDataM = r_rdata;
    assign BusErrM   = r_buserr;
    assign MisalignM = r_mis;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
// Directed scoreboard bench for mem_stage_lsu (ACK_TIMEOUT = 4). The stimulus
// process pushes the expected bus request and the expected completion into
// queues; a monitor pops and compares them when the DUT raises dbus_req or
// reaches its completion cycle. A small memory model answers with a
// programmable ack delay.
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        berr;
        logic        mis;
        int          stall;
        int          reqc;
    } resp_exp_t;

    logic        CLK;
    logic        RST;
    logic        MemWriteM;
    logic [2:0]  ResultSrcM;
    logic        signM;
    logic [1:0]  Byte_Half_OpM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        BusErrM;
    logic        MisalignM;

    mem_stage_lsu_if bus();

    mem_stage_lsu #(.ACK_TIMEOUT(4), .LOAD_SRC(3'b001)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .MemWriteM     (MemWriteM),
        .ResultSrcM    (ResultSrcM),
        .signM         (signM),
        .Byte_Half_OpM (Byte_Half_OpM),
        .ALUResultM    (ALUResultM),
        .WriteDataM    (WriteDataM),
        .dbus          (bus),
        .ReadDataM     (ReadDataM),
        .StallM        (StallM),
        .BusErrM       (BusErrM),
        .MisalignM     (MisalignM)
    );

    int total = 0;
    int bad   = 0;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];

    int          ack_wait    = 0;
    logic [31:0] slave_rdata = 32'h0;
    bit          stray       = 1'b0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: ack after ack_wait REQ cycles (never if ack_wait < 0);
    // stray drives an ack while no request is pending.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.dbus_ack   = 1'b0;
        bus.dbus_rdata = 32'h0;
        forever begin
            @(negedge CLK);
            if (bus.dbus_req && !RST) begin
                bus.dbus_ack   = (wcnt == ack_wait);
                bus.dbus_rdata = (wcnt == ack_wait) ? slave_rdata : 32'h0BAD_0BAD;
                wcnt++;
            end else begin
                wcnt = 0;
                bus.dbus_ack   = stray;
                bus.dbus_rdata = slave_rdata;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit        prev_stall;
        bit        prev_req;
        int        scnt;
        int        rcnt;
        bus_exp_t  cur;
        resp_exp_t re;
        prev_stall = 1'b0;
        prev_req   = 1'b0;
        scnt = 0;
        rcnt = 0;
        cur = '{1'b0, 32'h0, 4'h0, 32'h0};
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_stall = 1'b0;
                prev_req   = 1'b0;
                scnt = 0;
                rcnt = 0;
            end else begin
                if (StallM) scnt++;
                if (bus.dbus_req) begin
                    rcnt++;
                    if (!prev_req) begin
                        if (bus_q.size() == 0) begin
                            check("unexpected_req", 32'(bus.dbus_req), 32'h0);
                        end else begin
                            cur = bus_q.pop_front();
                            check("bus_we",    32'(bus.dbus_we), 32'(cur.we));
                            check("bus_addr",  bus.dbus_addr,    cur.addr);
                            check("bus_be",    32'(bus.dbus_be), 32'(cur.be));
                            check("bus_wdata", bus.dbus_wdata,   cur.wdata);
                        end
                    end else begin
                        check("bus_addr_stable",  bus.dbus_addr,  cur.addr);
                        check("bus_wdata_stable", bus.dbus_wdata, cur.wdata);
                    end
                end
                if (prev_stall && !StallM) begin
                    if (resp_q.size() == 0) begin
                        check("unexpected_done", 32'(prev_stall), 32'h0);
                    end else begin
                        re = resp_q.pop_front();
                        check("ReadDataM",   ReadDataM,        re.rdata);
                        check("BusErrM",     32'(BusErrM),     32'(re.berr));
                        check("MisalignM",   32'(MisalignM),   32'(re.mis));
                        check("stall_cycles", 32'(scnt),       32'(re.stall));
                        check("req_cycles",   32'(rcnt),       32'(re.reqc));
                    end
                    scnt = 0;
                    rcnt = 0;
                end else begin
                    check("no_pulse", {30'b0, BusErrM, MisalignM}, 32'h0);
                end
                prev_stall = StallM;
                prev_req   = bus.dbus_req;
            end
        end
    end

    task automatic clear_inputs();
        MemWriteM     = 1'b0;
        ResultSrcM    = 3'b000;
        signM         = 1'b0;
        Byte_Half_OpM = 2'b00;
        ALUResultM    = 32'h0;
        WriteDataM    = 32'h0;
    endtask

    task automatic issue(input logic we, input logic [2:0] src, input logic sgn,
                         input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input int aw, input logic [31:0] rd,
                         input bit has_bus, input bus_exp_t be, input resp_exp_t re);
        int n;
        @(posedge CLK); #2;
        ack_wait    = aw;
        slave_rdata = rd;
        if (has_bus) bus_q.push_back(be);
        resp_q.push_back(re);
        MemWriteM     = we;
        ResultSrcM    = src;
        signM         = sgn;
        Byte_Half_OpM = op;
        ALUResultM    = addr;
        WriteDataM    = wd;
        n = 0;
        do begin
            @(posedge CLK); #2;
            n++;
        end while (StallM && n < 40);
        if (n >= 40) check("complete_bound", 32'(StallM), 32'h0);
        // DONE cycle: the pipeline advances on the next edge.
        clear_inputs();
    endtask

    initial begin
        logic [31:0] held;
        RST = 1'b1;
        clear_inputs();
        repeat (2) @(posedge CLK);
        #2;
        check("rst_req",      32'(bus.dbus_req),  32'h0);
        check("rst_we",       32'(bus.dbus_we),   32'h0);
        check("rst_addr",     bus.dbus_addr,      32'h0);
        check("rst_be",       32'(bus.dbus_be),   32'h0);
        check("rst_wdata",    bus.dbus_wdata,     32'h0);
        check("rst_rdata",    ReadDataM,          32'h0);
        check("rst_stall",    32'(StallM),        32'h0);
        check("rst_pulses",   {30'b0, BusErrM, MisalignM}, 32'h0);
        RST = 1'b0;

        // lb signed, 0x1003, ack in first REQ cycle
        issue(1'b0, 3'b001, 1'b1, 2'b10, 32'h0000_1003, 32'h0, 0, 32'h80FF_1234,
              1'b1, '{1'b0, 32'h0000_1000, 4'hF, 32'h0},
              '{32'hFFFF_FF80, 1'b0, 1'b0, 2, 1});
        // sb 0xA5 to 0x3001, one wait cycle
        issue(1'b1, 3'b000, 1'b0, 2'b10, 32'h0000_3001, 32'h1234_56A5, 1, 32'hDEAD_BEEF,
              1'b1, '{1'b1, 32'h0000_3000, 4'b0010, 32'hA5A5_A5A5},
              '{32'h0, 1'b0, 1'b0, 3, 2});
        // lh signed 0x2000
        issue(1'b0, 3'b001, 1'b1, 2'b01, 32'h0000_2000, 32'h0, 0, 32'h1234_8001,
              1'b1, '{1'b0, 32'h0000_2000, 4'hF, 32'h0},
              '{32'hFFFF_8001, 1'b0, 1'b0, 2, 1});
        // sh to upper half 0x2006
        issue(1'b1, 3'b000, 1'b0, 2'b01, 32'h0000_2006, 32'h5A5A_C3D2, 0, 32'h0,
              1'b1, '{1'b1, 32'h0000_2004, 4'b1100, 32'hC3D2_C3D2},
              '{32'h0, 1'b0, 1'b0, 2, 1});
        // sw with size code 11, two wait cycles
        issue(1'b1, 3'b000, 1'b0, 2'b11, 32'h0000_2008, 32'hCAFE_F00D, 2, 32'h0,
              1'b1, '{1'b1, 32'h0000_2008, 4'hF, 32'hCAFE_F00D},
              '{32'h0, 1'b0, 1'b0, 4, 3});
        // lhu 0x2002, ack after 3 waits (same cycle as timeout limit)
        issue(1'b0, 3'b001, 1'b0, 2'b01, 32'h0000_2002, 32'h0, 3, 32'hBEEF_0000,
              1'b1, '{1'b0, 32'h0000_2000, 4'hF, 32'h0},
              '{32'h0000_BEEF, 1'b0, 1'b0, 5, 4});

        // Stray ack in IDLE must be ignored
        held = 32'h0000_BEEF;
        @(posedge CLK); #2;
        slave_rdata = 32'h7777_7777;
        stray = 1'b1;
        @(posedge CLK); #2;
        stray = 1'b0;
        @(posedge CLK); #2;
        check("stray_rdata", ReadDataM,          held);
        check("stray_req",   32'(bus.dbus_req),  32'h0);
        check("stray_stall", 32'(StallM),        32'h0);

        // Reset in the second REQ cycle
        ack_wait = -1;
        bus_q.push_back('{1'b0, 32'h0000_6004, 4'hF, 32'h0});
        MemWriteM     = 1'b0;
        ResultSrcM    = 3'b001;
        Byte_Half_OpM = 2'b00;
        ALUResultM    = 32'h0000_6004;
        @(posedge CLK); #2;
        @(posedge CLK); #2;
        check("pre_rst_req", 32'(bus.dbus_req), 32'h1);
        #1;
        RST = 1'b1;
        clear_inputs();
        #1;
        check("async_rst_req",   32'(bus.dbus_req), 32'h0);
        check("async_rst_stall", 32'(StallM),       32'h0);
        check("async_rst_rdata", ReadDataM,         32'h0);
        @(posedge CLK); #2;
        RST = 1'b0;

        // Clean restart: lbu 0x1001
        issue(1'b0, 3'b001, 1'b0, 2'b10, 32'h0000_1001, 32'h0, 0, 32'h80FF_1234,
              1'b1, '{1'b0, 32'h0000_1000, 4'hF, 32'h0},
              '{32'h0000_0012, 1'b0, 1'b0, 2, 1});
        // Timeout: no ack ever
        issue(1'b0, 3'b001, 1'b0, 2'b00, 32'h0000_5000, 32'h0, -1, 32'h0,
              1'b1, '{1'b0, 32'h0000_5000, 4'hF, 32'h0},
              '{32'h0, 1'b1, 1'b0, 5, 4});
        // Pipeline resumes after timeout
        issue(1'b0, 3'b001, 1'b0, 2'b00, 32'h0000_5010, 32'h0, 1, 32'h0102_0304,
              1'b1, '{1'b0, 32'h0000_5010, 4'hF, 32'h0},
              '{32'h0102_0304, 1'b0, 1'b0, 3, 2});

        // lw at misaligned 0x4002
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b001, 1'b0, 2'b00, 32'h0000_4002, 32'h0, 0, 32'h1122_3344,
              1'b0, '{1'b0, 32'h0, 4'h0, 32'h0},
              '{32'h0, 1'b0, 1'b1, 1, 0});
`else
        issue(1'b0, 3'b001, 1'b0, 2'b00, 32'h0000_4002, 32'h0, 0, 32'h1122_3344,
              1'b1, '{1'b0, 32'h0000_4000, 4'hF, 32'h0},
              '{32'h1122_3344, 1'b0, 1'b0, 2, 1});
`endif

        repeat (3) @(posedge CLK);
        #2;
        check("bus_q_drained",  32'(bus_q.size()),  32'h0);
        check("resp_q_drained", 32'(resp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
